// File: rtl/rca_pkg.sv
// ----------------------------------------------------------------------------
// rca_pkg
// Shared types and constants for the ripple-carry adder result collector.
//   rca_state_t           : collector FSM states
//   RCA_W / RCA_HALF_W    : full operand width and width of one result half
//   RCA_FLAG_LSB/MSB      : encoding of the adder half-select flag
// ----------------------------------------------------------------------------
package rca_pkg;

    localparam int RCA_W      = 32;
    localparam int RCA_HALF_W = 16;

    localparam logic RCA_FLAG_LSB = 1'b0;
    localparam logic RCA_FLAG_MSB = 1'b1;

    typedef enum logic [1:0] {
        RCA_IDLE,
        RCA_LSB,
        RCA_MSB,
        RCA_DONE
    } rca_state_t;

endpackage

// File: rtl/rca_phase_timer.sv
// ----------------------------------------------------------------------------
// rca_phase_timer
// Settle-time counter shared by the LSB and MSB read phases of the collector.
// Counts up from zero every cycle while clear is low; done is asserted while
// the count equals WAIT_CYC (the count holds there until cleared).
//   clk   in  clock, rising edge
//   rst   in  asynchronous active-high reset
//   clear in  synchronous clear of the count
//   done  out count has reached WAIT_CYC
// ----------------------------------------------------------------------------
module rca_phase_timer
    import rca_pkg::*;
#(
    parameter int unsigned WAIT_CYC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic done
);

    logic [3:0] count;

    assign done = (count == 4'(WAIT_CYC));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 4'd0;
        end else if (clear) begin
            count <= 4'd0;
        end else if (!done) begin
            count <= count + 4'd1;
        end
    end

endmodule

// File: rtl/rca_result_collector.sv
// ----------------------------------------------------------------------------
// rca_result_collector
// Transaction front-end for the power-gated 32-bit ripple-carry adder with a
// 16-bit time-multiplexed result port. Takes one add request, drives the
// adder operands, reads the LSB half then the MSB half (each after the
// WAIT_CYC settle time) and returns the reassembled sum and final carry.
//
// Parameter WAIT_CYC (1..15): cycles the adder needs after a flag change.
//
// Ports:
//   CLK, RST                   clock / asynchronous active-high reset
//   req_valid/req_ready        request handshake
//   req_a, req_b, req_cin      request operands
//   add_a, add_b, add_cin      operands driven to the adder
//   add_flag                   adder half select (0 = LSB, 1 = MSB)
//   add_s, add_cout            adder S_out / C_out
//   rsp_valid/rsp_ready        response handshake
//   rsp_sum, rsp_cout          assembled 32-bit sum and carry-out of bit 31
//   rsp_ovf                    signed overflow (only with RCA_OVF_DETECT_EN)
//   busy                       transaction in flight
//
// Build option: define RCA_OVF_DETECT_EN to add the rsp_ovf output.
// ----------------------------------------------------------------------------
module rca_result_collector
    import rca_pkg::*;
#(
    parameter int unsigned WAIT_CYC = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [RCA_W-1:0]      req_a,
    input  logic [RCA_W-1:0]      req_b,
    input  logic                  req_cin,
    output logic [RCA_W-1:0]      add_a,
    output logic [RCA_W-1:0]      add_b,
    output logic                  add_cin,
    output logic                  add_flag,
    input  logic [RCA_HALF_W-1:0] add_s,
    input  logic                  add_cout,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [RCA_W-1:0]      rsp_sum,
    output logic                  rsp_cout,
`ifdef RCA_OVF_DETECT_EN
    output logic                  rsp_ovf,
`endif
    output logic                  busy
);

    rca_state_t state, next_state;

    logic accept;
    logic capture_lsb;
    logic capture_msb;
    logic release_rsp;
    logic timer_clear;
    logic phase_done;

    rca_phase_timer #(
        .WAIT_CYC (WAIT_CYC)
    ) u_phase_timer (
        .clk   (CLK),
        .rst   (RST),
        .clear (timer_clear),
        .done  (phase_done)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= RCA_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The timer is held cleared outside the two read phases, so each phase
    // starts counting from zero on the edge that enters it.
    always_comb begin
        next_state  = state;
        accept      = 1'b0;
        capture_lsb = 1'b0;
        capture_msb = 1'b0;
        release_rsp = 1'b0;
        timer_clear = 1'b1;
        case (state)
            RCA_IDLE: begin
                if (req_valid && req_ready) begin
                    accept     = 1'b1;
                    next_state = RCA_LSB;
                end
            end
            RCA_LSB: begin
                timer_clear = phase_done;
                if (phase_done) begin
                    capture_lsb = 1'b1;
                    next_state  = RCA_MSB;
                end
            end
            RCA_MSB: begin
                timer_clear = phase_done;
                if (phase_done) begin
                    capture_msb = 1'b1;
                    next_state  = RCA_DONE;
                end
            end
            RCA_DONE: begin
                if (rsp_valid && rsp_ready) begin
                    release_rsp = 1'b1;
                    next_state  = RCA_IDLE;
                end
            end
            default: next_state = RCA_IDLE;
        endcase
    end

    // Status outputs are registered copies of the next state, so they line up
    // with the state register and req_ready stays low during reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            add_a     <= '0;
            add_b     <= '0;
            add_cin   <= 1'b0;
            add_flag  <= RCA_FLAG_LSB;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
`ifdef RCA_OVF_DETECT_EN
            rsp_ovf   <= 1'b0;
`endif
        end else begin
            req_ready <= (next_state == RCA_IDLE);
            rsp_valid <= (next_state == RCA_DONE);
            busy      <= (next_state != RCA_IDLE);
            if (accept) begin
                add_a    <= req_a;
                add_b    <= req_b;
                add_cin  <= req_cin;
                add_flag <= RCA_FLAG_LSB;
            end
            // Flag flips on the LSB capture edge so the MSB half gets a full
            // settle window before its own capture.
            if (capture_lsb) begin
                rsp_sum[RCA_HALF_W-1:0] <= add_s;
                add_flag                <= RCA_FLAG_MSB;
            end
            if (capture_msb) begin
                rsp_sum[RCA_W-1:RCA_HALF_W] <= add_s;
                rsp_cout                    <= add_cout;
`ifdef RCA_OVF_DETECT_EN
                rsp_ovf <= (add_a[RCA_W-1] == add_b[RCA_W-1]) &&
                           (add_s[RCA_HALF_W-1] != add_a[RCA_W-1]);
`endif
            end
            if (release_rsp) begin
                add_flag <= RCA_FLAG_LSB;
            end
        end
    end

endmodule

// File: tb/tb_rca_result_collector.sv
// ----------------------------------------------------------------------------
// tb_rca_result_collector
// Self-checking bench for rca_result_collector. Includes a behavioural model
// of the power-gated adder whose half result only becomes valid WAIT_CYC
// cycles after its operands or flag change (garbage before that), and a
// reference of the expected transaction computed with plain 33-bit addition.
// Define RCA_OVF_DETECT_EN to also check rsp_ovf.
// ----------------------------------------------------------------------------
module tb_rca_result_collector;

    localparam int unsigned W   = 2;
    localparam int          LAT = 2 * (int'(W) + 1);

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        req_cin = 1'b0;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_cin;
    logic        add_flag;
    logic [15:0] add_s = '0;
    logic        add_cout = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_sum;
    logic        rsp_cout;
`ifdef RCA_OVF_DETECT_EN
    logic        rsp_ovf;
`endif
    logic        busy;

    int checks = 0;
    int errors = 0;

    rca_result_collector #(
        .WAIT_CYC (W)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_flag  (add_flag),
        .add_s     (add_s),
        .add_cout  (add_cout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
`ifdef RCA_OVF_DETECT_EN
        .rsp_ovf   (rsp_ovf),
`endif
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    // Adder model: result is valid only once operands and flag have been
    // stable for W cycles; before that it returns random garbage.
    logic [31:0] last_a = '0;
    logic [31:0] last_b = '0;
    logic        last_cin = 1'b0;
    logic        last_flag = 1'b0;
    int          settle = 0;
    logic [32:0] model_full;

    always @(negedge CLK) begin
        if (add_a !== last_a || add_b !== last_b || add_cin !== last_cin || add_flag !== last_flag)
            settle = 0;
        else if (settle < 15)
            settle = settle + 1;
        last_a     = add_a;
        last_b     = add_b;
        last_cin   = add_cin;
        last_flag  = add_flag;
        model_full = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};
        if (settle >= int'(W)) begin
            add_s    = add_flag ? model_full[31:16] : model_full[15:0];
            add_cout = add_flag ? model_full[32] : 1'($urandom);
        end else begin
            add_s    = 16'($urandom);
            add_cout = 1'($urandom);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for req_ready, then presents one request for one edge.
    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b, input logic cin, input bit keep_valid);
        for (int i = 0; i < 20 && req_ready !== 1'b1; i++) @(negedge CLK);
        check_output("accept_ready", 32'(req_ready), 32'd1);
        req_a     = a;
        req_b     = b;
        req_cin   = cin;
        req_valid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        if (!keep_valid) req_valid = 1'b0;
    endtask

    // Follows one accepted transaction from the negedge after acceptance
    // through the response handshake, checking against plain arithmetic.
    task automatic follow_txn(input logic [31:0] a, input logic [31:0] b, input logic cin,
                              input int bp, input bit early, input bit inject);
        logic [32:0] full;
        logic        ovf;
        full = {1'b0, a} + {1'b0, b} + {32'd0, cin};
        ovf  = (a[31] == b[31]) && (full[31] != a[31]);
        if (early) rsp_ready = 1'b1;
        for (int k = 0; k < LAT; k++) begin
            check_output("phase_flag", 32'(add_flag), (k < int'(W) + 1) ? 32'd0 : 32'd1);
            check_output("early_valid", 32'(rsp_valid), 32'd0);
            check_output("busy_phase", 32'(busy), 32'd1);
            check_output("ready_phase", 32'(req_ready), 32'd0);
            check_output("hold_a", add_a, a);
            check_output("hold_cin", 32'(add_cin), 32'(cin));
            if (inject && k == 1) begin
                req_valid = 1'b1;
                req_a     = $urandom;
                req_b     = $urandom;
            end else if (inject) begin
                req_valid = 1'b0;
            end
            @(negedge CLK);
        end
        check_output("rsp_valid", 32'(rsp_valid), 32'd1);
        check_output("rsp_sum", rsp_sum, full[31:0]);
        check_output("rsp_cout", 32'(rsp_cout), 32'(full[32]));
        check_output("done_flag", 32'(add_flag), 32'd1);
`ifdef RCA_OVF_DETECT_EN
        check_output("rsp_ovf", 32'(rsp_ovf), 32'(ovf));
`endif
        if (!early) begin
            for (int i = 0; i < bp; i++) begin
                if (inject) begin
                    req_valid = 1'b1;
                    req_a     = $urandom;
                    req_b     = $urandom;
                end
                @(negedge CLK);
                check_output("bp_valid", 32'(rsp_valid), 32'd1);
                check_output("bp_sum", rsp_sum, full[31:0]);
                check_output("bp_cout", 32'(rsp_cout), 32'(full[32]));
                check_output("bp_ready", 32'(req_ready), 32'd0);
                check_output("bp_hold_a", add_a, a);
                check_output("bp_hold_b", add_b, b);
            end
        end
        if (inject) req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge CLK);
        check_output("post_valid", 32'(rsp_valid), 32'd0);
        check_output("post_ready", 32'(req_ready), 32'd1);
        check_output("post_busy", 32'(busy), 32'd0);
        check_output("post_flag", 32'(add_flag), 32'd0);
        check_output("post_sum", rsp_sum, full[31:0]);
        rsp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rc;
        int          rbp;
        bit          rearly;

        $display("[TB] start, WAIT_CYC=%0d", W);

        // Reset state
        repeat (2) @(negedge CLK);
        check_output("rst_req_ready", 32'(req_ready), 32'd0);
        check_output("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("rst_flag", 32'(add_flag), 32'd0);
        check_output("rst_sum", rsp_sum, 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_add_a", add_a, 32'd0);
        RST = 1'b0;
        @(negedge CLK);
        check_output("ready_after_rst", 32'(req_ready), 32'd1);

        // Full-width wrap with carry-out
        apply_stimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        follow_txn(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 1'b0, 1'b0);
        check_output("wrap_sum_const", rsp_sum, 32'h0000_0000);

        // Carry-in path
        apply_stimulus(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
        follow_txn(32'h1234_5678, 32'h1111_1111, 1'b1, 0, 1'b0, 1'b0);
        check_output("cin_sum_const", rsp_sum, 32'h2345_678A);

        // Backpressure with ignored requests during the transaction
        apply_stimulus(32'hCAFE_0123, 32'h0BAD_F00D, 1'b0, 1'b0);
        follow_txn(32'hCAFE_0123, 32'h0BAD_F00D, 1'b0, 5, 1'b0, 1'b1);

        // Consumer ready before the response appears
        apply_stimulus(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        follow_txn(32'h0000_FFFF, 32'h0000_0001, 1'b0, 0, 1'b1, 1'b0);

        // Signed overflow cases
        apply_stimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        follow_txn(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1, 1'b0, 1'b0);
        apply_stimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        follow_txn(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 1'b0, 1'b0);

        // Reset during the MSB phase
        apply_stimulus(32'hAAAA_5555, 32'h5555_AAAA, 1'b1, 1'b0);
        repeat (int'(W) + 2) @(negedge CLK);
        check_output("pre_rst_flag", 32'(add_flag), 32'd1);
        #2 RST = 1'b1;
        #1;
        check_output("arst_busy", 32'(busy), 32'd0);
        check_output("arst_flag", 32'(add_flag), 32'd0);
        check_output("arst_add_a", add_a, 32'd0);
        check_output("arst_req_ready", 32'(req_ready), 32'd0);
        check_output("arst_sum", rsp_sum, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check_output("ready_after_arst", 32'(req_ready), 32'd1);
        apply_stimulus(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
        follow_txn(32'h0000_0001, 32'h0000_0002, 1'b0, 0, 1'b0, 1'b0);

        // Back-to-back with req_valid held high
        apply_stimulus(32'h1000_0001, 32'h2000_0002, 1'b0, 1'b1);
        req_a = 32'h8765_4321;
        req_b = 32'h1234_5678;
        req_cin = 1'b1;
        follow_txn(32'h1000_0001, 32'h2000_0002, 1'b0, 0, 1'b1, 1'b0);
        rsp_ready = 1'b1;
        @(negedge CLK);
        check_output("b2b_busy", 32'(busy), 32'd1);
        check_output("b2b_add_a", add_a, 32'h8765_4321);
        req_valid = 1'b0;
        follow_txn(32'h8765_4321, 32'h1234_5678, 1'b1, 0, 1'b1, 1'b0);

        // Randomized transactions
        for (int n = 0; n < 8; n++) begin
            ra     = $urandom;
            rb     = $urandom;
            rc     = 1'($urandom);
            rbp    = int'($urandom_range(0, 3));
            rearly = (rbp == 0) ? bit'($urandom_range(0, 1)) : 1'b0;
            apply_stimulus(ra, rb, rc, 1'b0);
            follow_txn(ra, rb, rc, rbp, rearly, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rca_result_collector.md
# rca_result_collector

Transaction front-end for the 32-bit ripple-carry adder with power-gated halves and a 16-bit time-multiplexed result port. Accepts one 32-bit add request, drives the adder's operands and half-select `flag`, then reads the LSB half and the MSB half in turn. Each read waits out the power-management settle time. Delivers the reassembled 32-bit sum and final carry on a valid/ready response port. It is the reader end of the adder's `flag`/`S_out`/`C_out` interface.

## Interface
Parameters:
- `WAIT_CYC`, default 2: cycles the adder needs after a `flag` change (isolation/retention/power-switch settle plus adder register) before `add_s`/`add_cout` are valid; legal range 1..15.

Ports (reset is asynchronous and active-high):
- `CLK`  in  1  sole clock, rising edge
- `RST`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  collector can accept a request
- `req_a`, `req_b`  in  32 each  operands
- `req_cin`  in  1  carry-in
- `add_a`, `add_b`  out  32 each  operands to the adder
- `add_cin`  out  1  carry-in to the adder
- `add_flag`  out  1  half select: 0 = LSB half, 1 = MSB half
- `add_s`  in  16  adder `S_out`
- `add_cout`  in  1  adder `C_out`
- `rsp_valid`  out  1  result valid
- `rsp_ready`  in  1  consumer accepts the result
- `rsp_sum`  out  32  assembled sum
- `rsp_cout`  out  1  carry-out of bit 31
- `busy`  out  1  a transaction is in flight (any state other than IDLE)

## Operation
- States: IDLE, LSB, MSB, DONE.
- IDLE:
  - `req_ready`=1.
  - On `req_valid && req_ready`: register `req_a`, `req_b`, `req_cin` onto `add_a`/`add_b`/`add_cin`, set `add_flag`=0, clear the phase counter, go to LSB.
- LSB:
  - Counter increments each cycle.
  - When the count reaches `WAIT_CYC`: capture `add_s` into `rsp_sum[15:0]`, set `add_flag`=1, clear the counter, go to MSB.
  - The LSB carry is internal to the adder; `add_cout` is ignored in this phase.
- MSB:
  - Same counting.
  - When the count reaches `WAIT_CYC`: capture `add_s` into `rsp_sum[31:16]` and `add_cout` into `rsp_cout`, go to DONE.
- DONE:
  - `rsp_valid`=1.
  - `rsp_sum`/`rsp_cout` are held stable until `rsp_valid && rsp_ready`, then go to IDLE and set `add_flag`=0.
- `add_a`, `add_b`, `add_cin` stay constant from acceptance until the next acceptance.
- `req_valid` outside IDLE is ignored: no capture, no state change.
- Sum arithmetic is modulo 2^32; the carry comes only from the adder, and the collector performs no addition.

## Timing
- All outputs are registered.
- Reset values: every output is 0, including `add_flag` and `req_ready`; state is IDLE. `req_ready` rises on the first `CLK` edge after `RST` falls.
- Acceptance edge E0: state becomes LSB.
  - LSB capture at edge E0+`WAIT_CYC`+1.
  - MSB capture at edge E0+2·(`WAIT_CYC`+1).
  - `rsp_valid` is high from that edge on.
  - Latency is 6 cycles at the default `WAIT_CYC`.
- `add_flag` toggles on the same edge as the LSB capture, so the MSB half sees a full `WAIT_CYC`+1 cycles.
- Response handshake at edge Ed: `rsp_valid`=0 and `req_ready`=1 after Ed. The earliest next acceptance is Ed+1, so there is no overlap.
- `rsp_ready` may be high before `rsp_valid`; the handshake completes on the first DONE cycle.
- `RST` mid-transaction aborts immediately. Outputs return to their reset values and the partial result is discarded.

## Configuration
- `RCA_OVF_DETECT_EN` defined: adds output `rsp_ovf` (1 bit). It is the signed overflow `(add_a[31]==add_b[31]) && (rsp_sum[31]!=add_a[31])`, registered at the MSB capture, with reset value 0 and held with `rsp_sum`.
- `RCA_OVF_DETECT_EN` undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Package `rca_pkg` holds:
  - the state enum (`RCA_IDLE`, `RCA_LSB`, `RCA_MSB`, `RCA_DONE`);
  - `RCA_W`=32 and `RCA_HALF_W`=16;
  - `RCA_FLAG_LSB`=0 and `RCA_FLAG_MSB`=1.
- One sub-module, `rca_phase_timer`: a 4-bit counter with clear and `done` at `WAIT_CYC`. It is instantiated once and shared by both phases.

## Test plan
- Overflow of the full width: `req_a`=0xFFFFFFFF, `req_b`=0x00000001, `req_cin`=0, `WAIT_CYC`=2 -> `rsp_sum`=0x00000000, `rsp_cout`=1, `rsp_valid` 6 cycles after acceptance; `add_flag` is 0 for 3 cycles, then 1 for 3 cycles.
- Carry-in path: 0x12345678 + 0x11111111 with `req_cin`=1 -> `rsp_sum`=0x2345678A, `rsp_cout`=0.
- Backpressure: `rsp_ready` low for 5 cycles after `rsp_valid` -> sum/carry stable, `req_ready`=0, and a `req_valid` pulse during DONE is not captured (operands unchanged).
- Reset mid-operation: `RST` asserted during MSB -> all outputs 0 asynchronously; after release, a new 0x1+0x2 returns 0x00000003.
- Back-to-back: two requests with `req_valid` held high and `rsp_ready` high -> second accepted exactly one cycle after the first response handshake, and both results correct.
- Signed overflow (with `RCA_OVF_DETECT_EN`): 0x7FFFFFFF + 0x00000001 -> `rsp_ovf`=1, `rsp_sum`=0x80000000; 0xFFFFFFFF + 0xFFFFFFFF -> `rsp_ovf`=0, `rsp_cout`=1.
